// File: rtl/rcc_eth_clk_cfg_seq.sv
// Glitch-free Ethernet kernel clock reconfiguration sequencer (RCC bus-clock domain).
// Gates the MII clocks, switches epis_2/fes, checks that the rx clock is alive, then ungates.
module rcc_eth_clk_cfg_seq #(
    parameter int unsigned OFF_DLY = 8,
    parameter int unsigned SW_DLY  = 16,
    parameter int unsigned TGL_MIN = 4,
    parameter int unsigned TMO     = 1023,
    parameter int unsigned CW      = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic cfg_req,
    input  logic cfg_epis_2,
    input  logic cfg_fes,
    input  logic eth_rx_clk_tgl,
    input  logic rx_clk_en_in,
    input  logic tx_clk_en_in,
    output logic rx_clk_en_out,
    output logic tx_clk_en_out,
    output logic eth_rcc_epis_2,
    output logic eth_rcc_fes,
    output logic cfg_busy,
    output logic cfg_done,
    output logic cfg_err
);

    localparam logic [CW-1:0] OFF_LAST = CW'(OFF_DLY - 1);
    localparam logic [CW-1:0] SW_LAST  = CW'(SW_DLY - 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TMO - 1);
    localparam logic [CW-1:0] TGL_LAST = CW'(TGL_MIN - 1);
    localparam logic [CW-1:0] TGL_SAT  = CW'(TGL_MIN);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_GATE_OFF = 3'd1,
        S_APPLY    = 3'd2,
        S_SETTLE   = 3'd3,
        S_CHECK    = 3'd4,
        S_REVERT   = 3'd5,
        S_GATE_ON  = 3'd6
    } state_t;

    // Select pairs are kept as {epis_2, fes}
    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   r_tgl_cnt;
    logic            r_tgl_q;
    logic [1:0]      r_new;
    logic [1:0]      r_prev;
    logic [1:0]      r_sel;
    logic            r_busy;
    logic            r_done;
    logic            r_err;
    logic            r_rx_en;
    logic            r_tx_en;

    state_t          w_state_nxt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [CW-1:0]   w_tgl_cnt_nxt;
    logic [1:0]      w_new_nxt;
    logic [1:0]      w_prev_nxt;
    logic [1:0]      w_sel_nxt;
    logic            w_done_nxt;
    logic            w_err_nxt;
    logic            w_hold;
    logic            w_edge;
    logic [1:0]      w_req_sel;

    assign w_edge    = eth_rx_clk_tgl ^ r_tgl_q;
    assign w_req_sel = {cfg_epis_2, cfg_fes};

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_tgl_cnt_nxt = r_tgl_cnt;
        w_new_nxt     = r_new;
        w_prev_nxt    = r_prev;
        w_sel_nxt     = r_sel;
        w_done_nxt    = 1'b0;
        w_err_nxt     = r_err;

        unique case (r_state)
            S_IDLE: begin
                if (cfg_req) begin
                    w_err_nxt = 1'b0;
                    if (w_req_sel == r_sel) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_new_nxt   = w_req_sel;
                        w_prev_nxt  = r_sel;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_GATE_OFF;
                    end
                end
            end
            S_GATE_OFF: begin
                if (r_cnt == OFF_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_APPLY;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            S_APPLY: begin
                w_sel_nxt   = r_new;
                w_cnt_nxt   = '0;
                w_state_nxt = S_SETTLE;
            end
            S_SETTLE: begin
                if (r_cnt == SW_LAST) begin
                    w_cnt_nxt     = '0;
                    w_tgl_cnt_nxt = '0;
                    w_state_nxt   = S_CHECK;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            S_CHECK: begin
                // A completing edge takes priority over a coincident timeout
                if (w_edge && (r_tgl_cnt == TGL_LAST)) begin
                    w_tgl_cnt_nxt = TGL_SAT;
                    w_done_nxt    = 1'b1;
                    w_state_nxt   = S_GATE_ON;
                end else if (r_cnt == TMO_LAST) begin
                    w_sel_nxt   = r_prev;
                    w_err_nxt   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_REVERT;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                    if (w_edge && (r_tgl_cnt != TGL_SAT)) begin
                        w_tgl_cnt_nxt = r_tgl_cnt + CNT_ONE;
                    end
                end
            end
            S_REVERT: begin
                if (r_cnt == SW_LAST) begin
                    w_cnt_nxt   = '0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_GATE_ON;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            S_GATE_ON: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_hold = (w_state_nxt != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_tgl_cnt <= '0;
            r_tgl_q   <= 1'b0;
            r_new     <= 2'b00;
            r_prev    <= 2'b00;
            r_sel     <= 2'b00;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_rx_en   <= 1'b0;
            r_tx_en   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_tgl_cnt <= w_tgl_cnt_nxt;
            r_tgl_q   <= eth_rx_clk_tgl;
            r_new     <= w_new_nxt;
            r_prev    <= w_prev_nxt;
            r_sel     <= w_sel_nxt;
            r_busy    <= w_hold;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
            r_rx_en   <= rx_clk_en_in & ~w_hold;
            r_tx_en   <= tx_clk_en_in & ~w_hold;
        end
    end

    assign rx_clk_en_out  = r_rx_en;
    assign tx_clk_en_out  = r_tx_en;
    assign eth_rcc_epis_2 = r_sel[1];
    assign eth_rcc_fes    = r_sel[0];
    assign cfg_busy       = r_busy;
    assign cfg_done       = r_done;
    assign cfg_err        = r_err;

endmodule
